// File: rtl/prog_mem_arbiter.sv
// Program SPRAM arbiter: loader > host > cpu fetch, with a host-burst
// fairness guard and read-valid strobes aligned to the 1-cycle RAM latency.
module prog_mem_arbiter #(
  parameter int unsigned PROG_ADDR_WIDTH = 14,
  parameter int unsigned HOST_BURST_MAX  = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       i_loaded,
  // loader (write-only)
  input  logic                       i_ld_req,
  input  logic [PROG_ADDR_WIDTH-1:0] i_ld_addr,
  input  logic [7:0]                 i_ld_wdata,
  output logic                       o_ld_gnt,
  // host / debug (read-write)
  input  logic                       i_host_req,
  input  logic                       i_host_we,
  input  logic [PROG_ADDR_WIDTH-1:0] i_host_addr,
  input  logic [7:0]                 i_host_wdata,
  output logic                       o_host_gnt,
  output logic                       o_host_rvalid,
  // cpu instruction fetch (read-only)
  input  logic                       i_cpu_req,
  input  logic [PROG_ADDR_WIDTH-1:0] i_cpu_addr,
  output logic                       o_cpu_gnt,
  output logic                       o_cpu_rvalid,
  // shared read data
  output logic [7:0]                 o_rdata,
  // program SPRAM
  output logic                       o_mem_en,
  output logic                       o_mem_we,
  output logic [PROG_ADDR_WIDTH-1:0] o_mem_addr,
  output logic [7:0]                 o_mem_wdata,
  input  logic [7:0]                 i_mem_rdata
);

  localparam int unsigned STREAK_W = $clog2(HOST_BURST_MAX + 1);
  localparam int unsigned DATA_W   = 8;

  logic [STREAK_W-1:0]        r_host_streak;
  logic [PROG_ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_W-1:0]          r_mem_wdata;
  logic                       r_host_rvalid;
  logic                       r_cpu_rvalid;

  logic                       w_cpu_elig;
  logic                       w_cpu_force;
  logic                       w_ld_gnt;
  logic                       w_host_gnt;
  logic                       w_cpu_gnt;
  logic                       w_mem_en;
  logic                       w_mem_we;
  logic [PROG_ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_W-1:0]          w_mem_wdata;
  logic [STREAK_W-1:0]        w_host_streak_nxt;

  // Fixed-priority grant; a saturated host streak lets an eligible cpu past the host once.
  always_comb begin
    w_cpu_elig  = i_cpu_req && i_loaded;
    w_cpu_force = w_cpu_elig && (r_host_streak == STREAK_W'(HOST_BURST_MAX));
    w_ld_gnt    = i_ld_req;
    w_host_gnt  = !i_ld_req && i_host_req && !w_cpu_force;
    w_cpu_gnt   = !i_ld_req && w_cpu_elig && (!i_host_req || w_cpu_force);
  end

  // RAM port mux; when idle, address and write data hold their last driven value.
  always_comb begin
    w_mem_en    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    if (w_ld_gnt) begin
      w_mem_en    = 1'b1;
      w_mem_we    = 1'b1;
      w_mem_addr  = i_ld_addr;
      w_mem_wdata = i_ld_wdata;
    end else if (w_host_gnt) begin
      w_mem_en    = 1'b1;
      w_mem_we    = i_host_we;
      w_mem_addr  = i_host_addr;
      w_mem_wdata = i_host_wdata;
    end else if (w_cpu_gnt) begin
      w_mem_en    = 1'b1;
      w_mem_addr  = i_cpu_addr;
    end
  end

  // Host streak: counts host grants while cpu waits, saturating; cleared by a cpu grant or an ineligible cpu.
  always_comb begin
    w_host_streak_nxt = r_host_streak;
    if (w_cpu_gnt || !w_cpu_elig) begin
      w_host_streak_nxt = '0;
    end else if (w_host_gnt && (r_host_streak != STREAK_W'(HOST_BURST_MAX))) begin
      w_host_streak_nxt = r_host_streak + STREAK_W'(1);
    end
  end

  // Arbiter state, held RAM port values and read-valid pipeline.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_host_streak <= '0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_host_rvalid <= 1'b0;
      r_cpu_rvalid  <= 1'b0;
    end else begin
      r_host_streak <= w_host_streak_nxt;
      r_mem_addr    <= w_mem_addr;
      r_mem_wdata   <= w_mem_wdata;
      r_host_rvalid <= w_host_gnt && !i_host_we;
      r_cpu_rvalid  <= w_cpu_gnt;
    end
  end

  assign o_ld_gnt      = w_ld_gnt;
  assign o_host_gnt    = w_host_gnt;
  assign o_cpu_gnt     = w_cpu_gnt;
  assign o_host_rvalid = r_host_rvalid;
  assign o_cpu_rvalid  = r_cpu_rvalid;
  assign o_rdata       = i_mem_rdata;
  assign o_mem_en      = w_mem_en;
  assign o_mem_we      = w_mem_we;
  assign o_mem_addr    = w_mem_addr;
  assign o_mem_wdata   = w_mem_wdata;

endmodule

// File: tb/tb_prog_mem_arbiter.sv
// Directed bench for prog_mem_arbiter with a behavioural 1-cycle-latency SPRAM.
module tb_prog_mem_arbiter;

  localparam int unsigned AW = 14;

  logic          clk = 1'b0;
  logic          resetn;
  logic          i_loaded;
  logic          i_ld_req;
  logic [AW-1:0] i_ld_addr;
  logic [7:0]    i_ld_wdata;
  logic          o_ld_gnt;
  logic          i_host_req;
  logic          i_host_we;
  logic [AW-1:0] i_host_addr;
  logic [7:0]    i_host_wdata;
  logic          o_host_gnt;
  logic          o_host_rvalid;
  logic          i_cpu_req;
  logic [AW-1:0] i_cpu_addr;
  logic          o_cpu_gnt;
  logic          o_cpu_rvalid;
  logic [7:0]    o_rdata;
  logic          o_mem_en;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [7:0]    o_mem_wdata;
  logic [7:0]    i_mem_rdata;

  int errors = 0;
  int checks = 0;

  logic [7:0] ram [0:(1<<AW)-1];

  prog_mem_arbiter #(.PROG_ADDR_WIDTH(AW), .HOST_BURST_MAX(4)) dut (
    .clk(clk), .resetn(resetn), .i_loaded(i_loaded),
    .i_ld_req(i_ld_req), .i_ld_addr(i_ld_addr), .i_ld_wdata(i_ld_wdata), .o_ld_gnt(o_ld_gnt),
    .i_host_req(i_host_req), .i_host_we(i_host_we), .i_host_addr(i_host_addr),
    .i_host_wdata(i_host_wdata), .o_host_gnt(o_host_gnt), .o_host_rvalid(o_host_rvalid),
    .i_cpu_req(i_cpu_req), .i_cpu_addr(i_cpu_addr), .o_cpu_gnt(o_cpu_gnt),
    .o_cpu_rvalid(o_cpu_rvalid), .o_rdata(o_rdata),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
  );

  always #5 clk = ~clk;

  // SPRAM model: write or read on enable, read data one cycle later
  always @(posedge clk) begin
    if (o_mem_en) begin
      if (o_mem_we) ram[o_mem_addr] <= o_mem_wdata;
      else          i_mem_rdata     <= ram[o_mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance to 1ns after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0; i_loaded = 1'b0;
    i_ld_req = 1'b0; i_ld_addr = '0; i_ld_wdata = '0;
    i_host_req = 1'b0; i_host_we = 1'b0; i_host_addr = '0; i_host_wdata = '0;
    i_cpu_req = 1'b0; i_cpu_addr = '0; i_mem_rdata = '0;

    // reset state
    #3;
    chk("rst_host_rvalid", 32'(o_host_rvalid), 32'd0);
    chk("rst_cpu_rvalid", 32'(o_cpu_rvalid), 32'd0);
    chk("rst_mem_en", 32'(o_mem_en), 32'd0);
    chk("rst_mem_addr", 32'(o_mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(o_mem_wdata), 32'd0);
    #13; resetn = 1'b1;

    // loader streams 0..7 while cpu requests before loaded
    i_cpu_req = 1'b1; i_cpu_addr = 14'd3;
    for (int i = 0; i < 8; i++) begin
      i_ld_req = 1'b1; i_ld_addr = AW'(i); i_ld_wdata = 8'(8'h10 + i);
      #2;
      chk("ld_gnt", 32'(o_ld_gnt), 32'd1);
      chk("ld_cpu_gnt", 32'(o_cpu_gnt), 32'd0);
      chk("ld_mem_we", 32'(o_mem_we), 32'd1);
      chk("ld_mem_addr", 32'(o_mem_addr), 32'(i));
      chk("ld_mem_wdata", 32'(o_mem_wdata), 32'(8'h10 + i));
      cyc();
    end
    i_ld_req = 1'b0;
    #2;
    chk("preload_cpu_gnt", 32'(o_cpu_gnt), 32'd0);
    chk("idle_mem_en", 32'(o_mem_en), 32'd0);
    chk("idle_hold_addr", 32'(o_mem_addr), 32'd7);
    chk("idle_hold_wdata", 32'(o_mem_wdata), 32'h17);
    cyc();

    // cpu fetch 0..3 after loaded
    i_loaded = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_cpu_addr = AW'(i);
      #2;
      chk("cpu_gnt", 32'(o_cpu_gnt), 32'd1);
      chk("cpu_mem_we", 32'(o_mem_we), 32'd0);
      chk("cpu_mem_addr", 32'(o_mem_addr), 32'(i));
      cyc();
      chk("cpu_rvalid", 32'(o_cpu_rvalid), 32'd1);
      chk("cpu_rdata", 32'(o_rdata), 32'(8'h10 + i));
    end
    i_cpu_req = 1'b0;
    cyc();
    chk("cpu_rvalid_end", 32'(o_cpu_rvalid), 32'd0);

    // fairness: host and cpu held, expect H,H,H,H,C repeating
    i_host_req = 1'b1; i_host_we = 1'b0; i_host_addr = 14'd1;
    i_cpu_req = 1'b1; i_cpu_addr = 14'd2;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) chk("fair_host_rvalid", 32'(o_host_rvalid), 32'((k % 5) != 0));
      #2;
      chk("fair_host_gnt", 32'(o_host_gnt), 32'((k % 5) != 4));
      chk("fair_cpu_gnt", 32'(o_cpu_gnt), 32'((k % 5) == 4));
      cyc();
    end
    i_host_req = 1'b0; i_cpu_req = 1'b0;
    cyc();

    // all three request together; host write 0xAA@5 then read back
    i_ld_req = 1'b1; i_ld_addr = 14'd9; i_ld_wdata = 8'h55;
    i_host_req = 1'b1; i_host_we = 1'b1; i_host_addr = 14'd5; i_host_wdata = 8'hAA;
    i_cpu_req = 1'b1; i_cpu_addr = 14'd0;
    #2;
    chk("all_ld_gnt", 32'(o_ld_gnt), 32'd1);
    chk("all_host_gnt", 32'(o_host_gnt), 32'd0);
    chk("all_cpu_gnt", 32'(o_cpu_gnt), 32'd0);
    cyc();
    i_ld_req = 1'b0;
    #2;
    chk("hw_host_gnt", 32'(o_host_gnt), 32'd1);
    chk("hw_cpu_gnt", 32'(o_cpu_gnt), 32'd0);
    chk("hw_mem_we", 32'(o_mem_we), 32'd1);
    chk("hw_mem_addr", 32'(o_mem_addr), 32'd5);
    cyc();
    chk("hw_no_rvalid", 32'(o_host_rvalid), 32'd0);
    i_host_we = 1'b0;
    #2;
    chk("hr_host_gnt", 32'(o_host_gnt), 32'd1);
    chk("hr_mem_we", 32'(o_mem_we), 32'd0);
    cyc();
    chk("hr_rvalid", 32'(o_host_rvalid), 32'd1);
    chk("hr_rdata", 32'(o_rdata), 32'hAA);
    chk("hr_cpu_rvalid", 32'(o_cpu_rvalid), 32'd0);
    i_host_req = 1'b0; i_cpu_req = 1'b0;
    cyc();
    chk("hr_rvalid_end", 32'(o_host_rvalid), 32'd0);

    // reset during a host burst drops the in-flight read and clears the streak
    i_host_req = 1'b1; i_host_we = 1'b0; i_host_addr = 14'd1;
    i_cpu_req = 1'b1; i_cpu_addr = 14'd2;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("pre_host_gnt", 32'(o_host_gnt), 32'd1);
      if (k < 2) cyc();
    end
    #2; resetn = 1'b0;
    cyc();
    chk("rst_burst_host_rvalid", 32'(o_host_rvalid), 32'd0);
    resetn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #2;
      chk("post_rst_host_gnt", 32'(o_host_gnt), 32'(k != 4));
      chk("post_rst_cpu_gnt", 32'(o_cpu_gnt), 32'(k == 4));
      cyc();
    end

    // reset in flight after a cpu grant drops cpu_rvalid
    i_host_req = 1'b0; i_cpu_addr = 14'd1;
    #2;
    chk("pre_rst_cpu_gnt", 32'(o_cpu_gnt), 32'd1);
    #2; resetn = 1'b0;
    cyc();
    chk("rst_cpu_rvalid_drop", 32'(o_cpu_rvalid), 32'd0);
    resetn = 1'b1; i_cpu_req = 1'b0;
    #2;
    chk("rst_idle_mem_en", 32'(o_mem_en), 32'd0);
    chk("rst_held_addr", 32'(o_mem_addr), 32'd0);
    chk("rst_held_wdata", 32'(o_mem_wdata), 32'd0);
    cyc();
    i_cpu_req = 1'b1;
    #2;
    chk("resume_cpu_gnt", 32'(o_cpu_gnt), 32'd1);
    cyc();
    chk("resume_cpu_rvalid", 32'(o_cpu_rvalid), 32'd1);
    chk("resume_cpu_rdata", 32'(o_rdata), 32'h11);

    // loaded falls: cpu ineligible at once, in-flight rvalid still fires
    i_cpu_addr = 14'd2;
    #2;
    chk("lf_cpu_gnt", 32'(o_cpu_gnt), 32'd1);
    cyc();
    i_loaded = 1'b0;
    #2;
    chk("lf_cpu_gnt_off", 32'(o_cpu_gnt), 32'd0);
    chk("lf_cpu_rvalid", 32'(o_cpu_rvalid), 32'd1);
    chk("lf_cpu_rdata", 32'(o_rdata), 32'h12);
    cyc();
    chk("lf_cpu_rvalid_end", 32'(o_cpu_rvalid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
